// File: rtl/div_sched_pkg.sv
// Shared constants for the divider scheduler: defaults, FSM encoding, div-by-zero quotient.
package div_sched_pkg;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_W       = 32;
    localparam int unsigned DEF_TIMEOUT = 40;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [DEF_W-1:0] DIV0_Q = '1;

endpackage

// File: rtl/div_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request after `last`, as one-hot and index.
module rr_pick
    import div_sched_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    logic        found;
    int unsigned cand;

    // Scan from last+1 around the ring; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last) + k) % N_REQ;
            if (!found && req[IW'(cand)]) begin
                found             = 1'b1;
                grant[IW'(cand)]  = 1'b1;
                idx               = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one iterative divider among N_REQ requesters: round-robin accept, start/done
// handshake with watchdog, up-front divide-by-zero, result routed back to the issuer.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned W       = DEF_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   resp_valid,
    output logic [W-1:0]       resp_q,
    output logic [W-1:0]       resp_r,
    output logic               resp_err,
    output logic               busy,
    output logic               div_start,
    output logic [W-1:0]       div_a,
    output logic [W-1:0]       div_b,
    input  logic               div_done,
    input  logic [W-1:0]       div_q,
    input  logic [W-1:0]       div_r
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [1:0]       state, state_d;
    logic [IW-1:0]    last_grant, last_grant_d;
    logic [IW-1:0]    gnt_idx, gnt_idx_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [W-1:0]     a_d, b_d, q_d, r_d;
    logic             err_d;
    logic [N_REQ-1:0] pick_grant;
    logic [IW-1:0]    pick_idx;
    logic [W-1:0]     sel_a, sel_b;
    logic             accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req_valid),
        .last  (last_grant),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Ready only advertises the grant while idle and out of reset.
    assign req_ready = (state == ST_IDLE && !reset) ? pick_grant : '0;
    assign accept    = |(req_valid & req_ready);

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state;
        last_grant_d = last_grant;
        gnt_idx_d    = gnt_idx;
        cnt_d        = cnt;
        a_d          = div_a;
        b_d          = div_b;
        q_d          = resp_q;
        r_d          = resp_r;
        err_d        = resp_err;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    gnt_idx_d = pick_idx;
                    a_d       = sel_a;
                    b_d       = sel_b;
                    if (sel_b == '0) begin
                        q_d     = W'(DIV0_Q);
                        r_d     = sel_a;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt + CW'(1);
                // A completion in the final watchdog cycle still counts as success.
                if (div_done) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    q_d     = '0;
                    r_d     = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_grant_d = gnt_idx;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= IW'(N_REQ - 1);
            gnt_idx    <= '0;
            cnt        <= '0;
            div_a      <= '0;
            div_b      <= '0;
            resp_q     <= '0;
            resp_r     <= '0;
            resp_err   <= 1'b0;
            resp_valid <= '0;
            div_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            last_grant <= last_grant_d;
            gnt_idx    <= gnt_idx_d;
            cnt        <= cnt_d;
            div_a      <= a_d;
            div_b      <= b_d;
            resp_q     <= q_d;
            resp_r     <= r_d;
            resp_err   <= err_d;
            resp_valid <= (state_d == ST_RESP) ? (N_REQ'(1) << gnt_idx_d) : '0;
            div_start  <= (state_d == ST_ISSUE);
            busy       <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Directed-plus-random bench for div_sched; the bench itself plays the divider.
module tb_div_sched;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 40;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready, resp_valid;
    logic [W-1:0]   resp_q, resp_r, div_a, div_b, div_q, div_r;
    logic           resp_err, busy, div_start, div_done;

    int n_checks = 0;
    int n_fail   = 0;
    int last_g   = N - 1;

    div_sched #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_q     (resp_q),
        .resp_r     (resp_r),
        .resp_err   (resp_err),
        .busy       (busy),
        .div_start  (div_start),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_done   (div_done),
        .div_q      (div_q),
        .div_r      (div_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int g);
        return N'(1) << g;
    endfunction

    // Reference arbiter: first valid requester after the previous winner.
    function automatic int rr_ref(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    // Present a lone request in an idle cycle; returns at the following negedge.
    task automatic issue(input int g, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[g*W +: W] = a;
        req_b[g*W +: W] = b;
        req_valid[g]    = 1'b1;
        #1;
        chk("ready", req_ready, oh(g));
        @(negedge clk);
        req_valid[g] = 1'b0;
    endtask

    // Called one cycle after accept; plays a divider with latency lat (<0: never) and
    // checks the response. Returns at the negedge of the response cycle.
    task automatic serve(input int g, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        int  resp_cyc;
        bit  tmo;
        if (b == '0) begin
            chk("dz_start", div_start, 0);
            chk("dz_valid", resp_valid, oh(g));
            chk("dz_q", resp_q, {W{1'b1}});
            chk("dz_r", resp_r, a);
            chk("dz_err", resp_err, 1);
            last_g = g;
            return;
        end
        chk("start", div_start, 1);
        chk("div_a", div_a, a);
        chk("div_b", div_b, b);
        chk("busy", busy, 1);
        chk("no_resp_issue", resp_valid, 0);
        div_done = 1'b1;
        div_q    = $urandom;
        div_r    = $urandom;
        tmo      = !(lat >= 1 && lat <= TO);
        resp_cyc = tmo ? TO + 1 : lat + 1;
        for (int k = 1; k < resp_cyc; k++) begin
            @(negedge clk);
            if (k == 1) chk("start_pulse", div_start, 0);
            if (k == resp_cyc - 1) begin
                chk("early_resp", resp_valid, 0);
                chk("hold_a", div_a, a);
                chk("hold_b", div_b, b);
            end
            div_done = (k == lat);
            div_q    = (k == lat) ? a / b : $urandom;
            div_r    = (k == lat) ? a % b : $urandom;
        end
        @(negedge clk);
        div_done = 1'b0;
        chk("resp_valid", resp_valid, oh(g));
        chk("resp_q", resp_q, tmo ? 0 : a / b);
        chk("resp_r", resp_r, tmo ? 0 : a % b);
        chk("resp_err", resp_err, tmo ? 1 : 0);
        last_g = g;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_valid", resp_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ca [N];
        logic [W-1:0] cb [N];
        logic [W-1:0] a, b;
        int           g, eg, lat;

        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        div_done = 1'b0; div_q = '0; div_r = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", div_start, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        chk("rst_q", resp_q, 0);
        chk("rst_r", resp_r, 0);
        chk("rst_err", resp_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Requester 0 first after reset; withdrawing before the edge leaves no trace.
        req_valid = '1;
        #1 chk("rst_priority", req_ready, oh(0));
        req_valid = '0;
        idle_chk();

        issue(0, 100, 7);
        serve(0, 100, 7, 33);
        idle_chk();

        issue(2, 32'h1234, 0);
        serve(2, 32'h1234, 0, 0);
        idle_chk();

        // Timeout, then a late done must not produce a response.
        issue(1, 32'd5000, 32'd9);
        serve(1, 32'd5000, 32'd9, -1);
        repeat (5) @(negedge clk);
        div_done = 1'b1; div_q = 32'd7; div_r = 32'd7;
        @(negedge clk);
        div_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stray_valid", resp_valid, 0);
            chk("stray_busy", busy, 0);
            @(negedge clk);
        end

        // Done arriving in the last watchdog cycle.
        issue(3, 32'd1000, 32'd3);
        serve(3, 32'd1000, 32'd3, TO);
        idle_chk();

        // Contention: everyone valid, each re-requests after its own response.
        for (int i = 0; i < N; i++) begin
            ca[i] = $urandom;
            cb[i] = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
            req_a[i*W +: W] = ca[i];
            req_b[i*W +: W] = cb[i];
        end
        req_valid = '1;
        for (int op = 0; op < 2 * N; op++) begin
            #1;
            eg = rr_ref(req_valid, last_g);
            chk("cont_ready", req_ready, oh(eg));
            @(negedge clk);
            req_valid[eg] = 1'b0;
            serve(eg, ca[eg], cb[eg], $urandom_range(1, 10));
            if (op < 2 * N - 1) begin
                ca[eg] = $urandom;
                cb[eg] = ($urandom_range(0, 4) == 0) ? '0 : $urandom_range(1, 1000);
                req_a[eg*W +: W] = ca[eg];
                req_b[eg*W +: W] = cb[eg];
                req_valid[eg] = 1'b1;
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
        end
        chk("cont_busy", busy, 0);

        // Random lone requests, latencies straddling the watchdog.
        for (int n = 0; n < 6; n++) begin
            g   = $urandom_range(0, N - 1);
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? '0 : $urandom_range(1, 50000);
            lat = $urandom_range(1, TO + 5);
            issue(g, a, b);
            serve(g, a, b, lat);
            idle_chk();
        end

        issue(2, 32'd77, 32'd5);
        serve(2, 32'd77, 32'd5, 3);
        idle_chk();

        // Reset while waiting on the divider.
        issue(0, 32'd999, 32'd4);
        chk("rw_start", div_start, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rw_valid", resp_valid, 0);
        chk("rw_busy", busy, 0);
        chk("rw_start0", div_start, 0);
        chk("rw_div_a", div_a, 0);
        chk("rw_div_b", div_b, 0);
        chk("rw_err", resp_err, 0);
        @(negedge clk);
        reset  = 1'b0;
        last_g = N - 1;
        @(negedge clk);
        chk("rw_quiet", resp_valid, 0);

        req_a[3*W +: W] = 32'd50;
        req_b[3*W +: W] = 32'd6;
        req_valid[3]    = 1'b1;
        req_a[1*W +: W] = 32'd123456;
        req_b[1*W +: W] = 32'd789;
        req_valid[1]    = 1'b1;
        #1;
        chk("rw_priority", req_ready, oh(rr_ref(req_valid, last_g)));
        @(negedge clk);
        req_valid[1] = 1'b0;
        serve(1, 32'd123456, 32'd789, 6);
        @(negedge clk);
        issue(3, 32'd50, 32'd6);
        serve(3, 32'd50, 32'd6, 2);
        idle_chk();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Shares one iterative 32-bit divider among `N_REQ` requesters in the diffusion datapath, such as the per-lane PPR residual normalisers. It does three things: round-robin arbitration, operand capture, and a divider start/done handshake with watchdog timeout. It also catches divide-by-zero up front. Each result returns to the requester that issued it, with an error flag.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 32: operand and result width.
- `TIMEOUT`, 40: maximum cycles in WAIT before a divider call is abandoned.

Ports:
- `clk` in, 1: clock, rising edge.
- `reset` in, 1: asynchronous, active-high.
- `req_valid` in, `N_REQ`: per-requester request.
- `req_a` in, `N_REQ*W`: dividends; requester i occupies bits [i*W +: W].
- `req_b` in, `N_REQ*W`: divisors, same packing as `req_a`.
- `req_ready` out, `N_REQ`: one-hot; the request is accepted in any cycle where `req_valid[i] & req_ready[i]`.
- `resp_valid` out, `N_REQ`: one-hot, 1-cycle pulse that delivers the result.
- `resp_q` out, W: quotient.
- `resp_r` out, W: remainder.
- `resp_err` out, 1: divide-by-zero or timeout.
- `busy` out, 1: high whenever the state is not IDLE.
- `div_start` out, 1: 1-cycle start pulse to the divider.
- `div_a` out, W: latched dividend to the divider.
- `div_b` out, W: latched divisor to the divider.
- `div_done` in, 1: divider result-valid, sampled only in WAIT.
- `div_q` in, W: divider quotient.
- `div_r` in, W: divider remainder.

## Operation
The block is a four-state machine: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - The round-robin pick starts at `last_grant+1` mod `N_REQ` and selects the first asserted `req_valid`.
  - `req_ready` is combinational and equals the one-hot grant, only in IDLE; it is 0 when no request is pending.
  - On accept, the block latches `g`, A and B.
  - If B==0, it goes to RESP with err=1, q=all-ones, r=A. The divider is not touched.
  - Otherwise it goes to ISSUE.
- **ISSUE:**
  - `div_start`=1 for exactly this cycle.
  - `div_a`/`div_b` hold the latched operands, stable from ISSUE until the block leaves WAIT.
  - The watchdog counter clears to 0.
  - The next state is WAIT unconditionally.
  - `div_done` seen in ISSUE is ignored.
- **WAIT:**
  - The counter increments each cycle.
  - On `div_done`: latch `div_q`/`div_r`, err=0, go to RESP.
  - Otherwise, when the counter == `TIMEOUT-1`: q=0, r=0, err=1, go to RESP.
  - If `div_done` and timeout occur in the same cycle, done wins.
- **RESP:**
  - `resp_valid[g]`=1 with q/r/err registered.
  - `last_grant`←g.
  - Go to IDLE.
  - There is no backpressure; requesters must sample in that cycle.
- A stray `div_done` outside WAIT, for example after a timeout, is ignored.
- Dropping `req_valid` before it is accepted is legal and has no side effect.
- Each requester has at most one outstanding request and waits for its own `resp_valid` before issuing another.

## Timing
- **Reset values:**
  - State IDLE, `last_grant`=`N_REQ-1` (requester 0 has first priority).
  - All outputs 0: `req_ready`, `resp_*`, `div_*`, `busy`, counter.
- **Latency:** with accept at cycle t:
  - `div_start` at t+1.
  - If `div_done` arrives at t+1+L (L≥1), `resp_valid` is at t+2+L.
  - Divide-by-zero: `resp_valid` at t+1.
  - Timeout: `resp_valid` at t+2+`TIMEOUT`.
- **Throughput:** one operation in flight. The next accept happens no earlier than the cycle after RESP, so the back-to-back minimum is L+3 cycles per divide.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,2,3,0,… Any waiting requester is served within `N_REQ` operations.
- **Reset mid-operation:** the block aborts immediately to IDLE with no response. Any in-flight divider result is then discarded, because `div_done` is ignored in IDLE.

## Structure
- **Package `div_sched_pkg`:** state enum (IDLE, ISSUE, WAIT, RESP), default `W`/`N_REQ`/`TIMEOUT` constants, and the divide-by-zero quotient constant (all-ones).
- **Sub-module `rr_pick`:** combinational; inputs `req[N_REQ]` and `last[clog2 N_REQ]`; outputs a one-hot grant and an index. Reused by later diffusion-lane arbiters.
- The FSM, operand/result registers and watchdog counter live in `div_sched`.

## Test plan
- **Single request:** req0 A=100, B=7; divider model L=33 → `div_start` at t+1, `resp_valid[0]` at t+35, q=14, r=2, err=0.
- **Divide-by-zero:** req2 A=0x1234, B=0 → no `div_start`; `resp_valid[2]` at t+1, q=0xFFFFFFFF, r=0x1234, err=1.
- **Contention:** all four valid continuously, distinct operands → grant order 0,1,2,3,0; each result matches its own A/B and its own `resp_valid` bit.
- **Timeout:** divider model never asserts done; `TIMEOUT`=40 → `resp_valid` at t+42 with err=1, q=r=0. A stray `div_done` 5 cycles later causes no response.
- **Done/timeout collision:** `div_done` on the same cycle the counter hits 39 → err=0, divider q/r delivered.
- **Reset mid-WAIT:** assert `reset` 10 cycles after `div_start` → all outputs 0 immediately. After release, a new request to req1 is served normally with requester 0 priority restored.
